// File: rtl/uart_tx_framer_if.sv
// Valid/ready word handshake between the transmit data source (master)
// and the UART transmit framer (slave).
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start + data (LSB first) + optional parity + stop bit(s),
// advancing one bit per baud_tick from the external baud timer it enables.
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_framer_if.slave  tx,
  input  logic             baud_tick,
  output logic             baud_en,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] data_q, data_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 stop_q, stop_n;
  logic                 par_q, par_n;
  logic                 ready_q, ready_n;
  logic                 serial_n, en_n, busy_n, done_n;

  assign tx.tx_ready = ready_q;

  always_comb begin
    state_n = state;
    data_n  = data_q;
    idx_n   = idx_q;
    stop_n  = stop_q;
    par_n   = par_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (tx.tx_valid && ready_q) begin
          state_n = START;
          data_n  = tx.tx_data;
          par_n   = (^tx.tx_data) ^ (PARITY_ODD != 0);
          idx_n   = '0;
        end
      end
      START: begin
        if (baud_tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
            stop_n  = 1'b0;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) begin
          state_n = STOP;
          stop_n  = 1'b0;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every registered output
  // changes on the same edge that samples baud_tick.
  always_comb begin
    serial_n = 1'b1;
    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = data_n[idx_n];
      PARITY:  serial_n = par_n;
      default: serial_n = 1'b1;
    endcase
    en_n    = (state_n != IDLE);
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      baud_en   <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      idx_q     <= idx_n;
      stop_q    <= stop_n;
      par_q     <= par_n;
      tx_serial <= serial_n;
      baud_en   <= en_n;
      tx_busy   <= busy_n;
      tx_done   <= done_n;
      ready_q   <= ready_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: four parameter variants, each driven by
// its own baud timer of period P, checked against hand-computed line frames.
module tb_uart_tx_framer;

  localparam int P = 10;

  logic clk;
  logic reset;
  logic force_tick;
  logic       valid [4];
  logic [7:0] data  [4];
  logic ready [4];
  logic en    [4];
  logic serial[4];
  logic busy  [4];
  logic done  [4];
  logic tk    [4];
  logic tick_in [4];
  int   cnt   [4];

  int checks;
  int errors;

  logic ser_w [0:255];
  logic done_w[0:255];
  logic rdy_w [0:255];
  logic busy_w[0:255];
  logic en_w  [0:255];

  typedef struct {
    int         d;
    logic [7:0] word;
    logic [11:0] frame;
    int         nbits;
  } vec_t;
  vec_t vecs[10];

  uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if1 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_valid = valid[0];
  assign if0.tx_data  = data[0];
  assign ready[0]     = if0.tx_ready;
  assign if1.tx_valid = valid[1];
  assign if1.tx_data  = data[1];
  assign ready[1]     = if1.tx_ready;
  assign if2.tx_valid = valid[2];
  assign if2.tx_data  = data[2];
  assign ready[2]     = if2.tx_ready;
  assign if3.tx_valid = valid[3];
  assign if3.tx_data  = data[3];
  assign ready[3]     = if3.tx_ready;

  assign tick_in[0] = tk[0] | force_tick;
  assign tick_in[1] = tk[1] | force_tick;
  assign tick_in[2] = tk[2] | force_tick;
  assign tick_in[3] = tk[3] | force_tick;

  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx(if0.slave), .baud_tick(tick_in[0]), .baud_en(en[0]),
    .tx_serial(serial[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tx(if1.slave), .baud_tick(tick_in[1]), .baud_en(en[1]),
    .tx_serial(serial[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .tx(if2.slave), .baud_tick(tick_in[2]), .baud_en(en[2]),
    .tx_serial(serial[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .tx(if3.slave), .baud_tick(tick_in[3]), .baud_en(en[3]),
    .tx_serial(serial[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud timer: clears while disabled, registered tick every P enabled cycles.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!en[i]) begin
        cnt[i] <= 0;
        tk[i]  <= 1'b0;
      end else if (cnt[i] == P - 1) begin
        cnt[i] <= 0;
        tk[i]  <= 1'b1;
      end else begin
        cnt[i] <= cnt[i] + 1;
        tk[i]  <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presents a word and returns just after the accepting edge.
  task automatic start_frame(input int d, input logic [7:0] word);
    int n;
    @(negedge clk);
    data[d]  = word;
    valid[d] = 1'b1;
    n = 0;
    while (!ready[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", int'(n < 300), 1);
    @(posedge clk);
  endtask

  // Cycle c holds outputs after accept edge + c; data/valid may change at c.
  task automatic record(input int d, input int ncyc, input int chg_c,
                        input logic [7:0] chg_v, input int drop_c);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ser_w[c]  = serial[d];
      done_w[c] = done[d];
      rdy_w[c]  = ready[d];
      busy_w[c] = busy[d];
      en_w[c]   = en[d];
      if (c == chg_c) data[d] = chg_v;
      if (c == drop_c) valid[d] = 1'b0;
    end
  endtask

  // START spans cycles 0..P, bit k>0 spans 1+kP..kP+P, done lands at 1+nbits*P.
  task automatic check_frame(input int base, input logic [11:0] frame,
                             input int nbits, input string name);
    int first, last, bad, dc, dcount;
    for (int k = 0; k < nbits; k++) begin
      first = base + ((k == 0) ? 0 : 1 + k * P);
      last  = base + k * P + P;
      chk($sformatf("%s bit%0d first", name, k), int'(ser_w[first]), int'(frame[k]));
      chk($sformatf("%s bit%0d last", name, k), int'(ser_w[last]), int'(frame[k]));
    end
    bad = 0;
    for (int c = base; c <= base + nbits * P; c++)
      if (!busy_w[c] || rdy_w[c] || !en_w[c]) bad++;
    chk($sformatf("%s busy_cycles_bad", name), bad, 0);
    dc = base + 1 + nbits * P;
    chk($sformatf("%s done_at_%0d", name, dc - base), int'(done_w[dc]), 1);
    chk($sformatf("%s ready_at_done", name), int'(rdy_w[dc]), 1);
    chk($sformatf("%s baud_en_at_done", name), int'(en_w[dc]), 0);
    chk($sformatf("%s busy_at_done", name), int'(busy_w[dc]), 0);
    chk($sformatf("%s line_at_done", name), int'(ser_w[dc]), 1);
    dcount = 0;
    for (int c = base; c <= dc + 1; c++)
      if (done_w[c]) dcount++;
    chk($sformatf("%s done_pulses", name), dcount, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int bad, hi, dcount;
    checks     = 0;
    errors     = 0;
    force_tick = 1'b0;
    reset      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end

    // frame bit k = k-th bit on the line: {stop(s), [parity], data, start}
    vecs[0] = '{0, 8'hA5, 12'h34A, 10};
    vecs[1] = '{0, 8'h00, 12'h200, 10};
    vecs[2] = '{0, 8'hFF, 12'h3FE, 10};
    vecs[3] = '{1, 8'h01, 12'h402, 11};
    vecs[4] = '{1, 8'hFF, 12'h7FE, 11};
    vecs[5] = '{2, 8'h03, 12'h406, 11};
    vecs[6] = '{2, 8'h07, 12'h60E, 11};
    vecs[7] = '{2, 8'h00, 12'h400, 11};
    vecs[8] = '{3, 8'hFF, 12'h7FE, 11};
    vecs[9] = '{3, 8'hA5, 12'h74A, 11};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset dut%0d tx_serial", i), int'(serial[i]), 1);
      chk($sformatf("reset dut%0d baud_en", i), int'(en[i]), 0);
      chk($sformatf("reset dut%0d tx_busy", i), int'(busy[i]), 0);
      chk($sformatf("reset dut%0d tx_done", i), int'(done[i]), 0);
      chk($sformatf("reset dut%0d tx_ready", i), int'(ready[i]), 1);
    end

    // baud_tick while idle must be ignored
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!serial[0] || en[0] || busy[0] || !ready[0] || done[0]) bad++;
      force_tick = (i % 2 == 0);
    end
    force_tick = 1'b0;
    chk("idle_tick bad_cycles", bad, 0);

    for (int v = 0; v < 10; v++) begin
      start_frame(vecs[v].d, vecs[v].word);
      record(vecs[v].d, vecs[v].nbits * P + 4, -1, 8'h00, 0);
      check_frame(0, vecs[v].frame, vecs[v].nbits, $sformatf("vec%0d", v));
    end

    // two stop bits: line high for 2P cycles after the last data bit
    start_frame(3, 8'hFF);
    record(3, 11 * P + 4, -1, 8'h00, 0);
    hi = 0;
    for (int c = 9 * P + 1; c <= 11 * P; c++)
      if (ser_w[c]) hi++;
    chk("stop2 high_cycles", hi, 2 * P);
    chk("stop2 no_done_after_first_stop", int'(done_w[10 * P + 1]), 0);
    chk("stop2 done_after_second_stop", int'(done_w[11 * P + 1]), 1);

    // back-to-back with valid held; data changes mid-frame to the next word
    start_frame(0, 8'h11);
    record(0, 2 * (10 * P + 1) + 4, 50, 8'h22, 10 * P + 2);
    check_frame(0, 12'h222, 10, "b2b_first");
    chk("b2b idle_gap_ready", int'(rdy_w[10 * P + 1]), 1);
    chk("b2b idle_gap_baud_en", int'(en_w[10 * P + 1]), 0);
    check_frame(10 * P + 2, 12'h244, 10, "b2b_second");

    // reset mid-frame during data bit 3 of 0x5A
    start_frame(0, 8'h5A);
    record(0, 46, -1, 8'h00, 0);
    chk("midreset pre baud_en", int'(en[0]), 1);
    chk("midreset pre line", int'(serial[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset tx_serial", int'(serial[0]), 1);
    chk("midreset baud_en", int'(en[0]), 0);
    chk("midreset tx_busy", int'(busy[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!serial[0] || en[0] || busy[0] || !ready[0]) bad++;
      if (done[0]) dcount++;
    end
    chk("midreset idle_bad_cycles", bad, 0);
    chk("midreset done_pulses", dcount, 0);
    start_frame(0, 8'h3C);
    record(0, 10 * P + 4, -1, 8'h00, 0);
    check_frame(0, 12'h278, 10, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
